// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard signals between the pipeline stages (master) and hazard_ctrl (slave)
interface hazard_ctrl_if #(parameter int XLEN = 32);
  logic [4:0]      id_rs1, id_rs2;
  logic            id_rs1_used, id_rs2_used;
  logic [4:0]      ex_rd;
  logic            ex_mem_read, ex_valid;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            mc_start, mc_done;
  logic            imem_ready;
  logic            pc_en, fd_en, fd_flush, de_flush, pc_sel;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      state;
  logic            mc_err;
  logic [31:0]     stall_cycles, flush_count;
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read, ex_valid,
           branch_taken, branch_target, mc_start, mc_done, imem_ready,
    input  pc_en, fd_en, fd_flush, de_flush, pc_sel, redirect_pc, state, mc_err,
           stall_cycles, flush_count
  );
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read, ex_valid,
           branch_taken, branch_target, mc_start, mc_done, imem_ready,
    output pc_en, fd_en, fd_flush, de_flush, pc_sel, redirect_pc, state, mc_err,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect control for load-use, multi-cycle EX ops and branch refill.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles/flush_count performance counters.
module hazard_ctrl #(
  parameter int XLEN       = 32,
  parameter int MC_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1, REFILL = 2'd2} state_t;
  localparam int CW = $clog2(MC_TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(MC_TIMEOUT - 1);
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          lu;
  logic          pc_en_c, fd_en_c, fd_flush_c, de_flush_c, pc_sel_c;
  assign lu = hz.ex_valid & hz.ex_mem_read & (|hz.ex_rd) &
              ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) | (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    err_d      = err_q;
    pc_en_c    = 1'b0;
    fd_en_c    = 1'b0;
    fd_flush_c = 1'b0;
    de_flush_c = 1'b0;
    pc_sel_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          {pc_sel_c, pc_en_c, fd_flush_c, de_flush_c} = 4'hf;
          state_d = REFILL;
        end else if (hz.mc_start) begin
          state_d = MC_WAIT;
        end else if (lu) begin
          de_flush_c = 1'b1;
        end else begin
          pc_en_c = hz.imem_ready;
          fd_en_c = hz.imem_ready;
        end
      end
      MC_WAIT: begin
        // EX is held here, so a branch_taken cannot be resolved and is ignored
        cnt_d = cnt_q + 1'b1;
        if (hz.mc_done) begin
          state_d = RUN;
        end else if (cnt_q == TERM) begin
          err_d   = 1'b1;
          state_d = RUN;
        end
      end
      REFILL: begin
        if (hz.branch_taken) begin
          {pc_sel_c, pc_en_c, fd_flush_c, de_flush_c} = 4'hf;
        end else if (hz.imem_ready) begin
          pc_en_c = 1'b1;
          fd_en_c = 1'b1;
          state_d = RUN;
        end else begin
          fd_flush_c = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign hz.pc_en       = rst_n & pc_en_c;
  assign hz.fd_en       = rst_n & fd_en_c;
  assign hz.fd_flush    = ~rst_n | fd_flush_c;
  assign hz.de_flush    = ~rst_n | de_flush_c;
  assign hz.pc_sel      = rst_n & pc_sel_c;
  assign hz.redirect_pc = XLEN'(hz.branch_target);
  assign hz.state       = state_q;
  assign hz.mc_err      = err_q;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_q + {31'b0, ~pc_en_c};
      flush_q <= flush_q + {31'b0, pc_sel_c};
    end
  end
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with hand-computed expectations
module tb_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  int st_exp = 0;
  int fl_exp = 0;
  hazard_ctrl_if #(.XLEN(32)) hz ();
  hazard_ctrl #(.XLEN(32), .MC_TIMEOUT(64)) dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_used = 0; hz.id_rs2_used = 0;
    hz.ex_rd = '0; hz.ex_mem_read = 0; hz.ex_valid = 0;
    hz.branch_taken = 0; hz.branch_target = '0;
    hz.mc_start = 0; hz.mc_done = 0; hz.imem_ready = 1;
  endtask
  task automatic load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic v);
    hz.ex_valid = v; hz.ex_mem_read = 1; hz.ex_rd = rd;
    hz.id_rs1 = rs1; hz.id_rs1_used = u1; hz.id_rs2 = rs2; hz.id_rs2_used = u2;
  endtask
  task automatic step(input string tag, input logic pe, input logic fe, input logic ff,
                      input logic df, input logic ps, input logic [1:0] st);
    #1;
    check({tag, ".pc_en"}, 64'(hz.pc_en), 64'(pe));
    if (fe !== 1'bx) check({tag, ".fd_en"}, 64'(hz.fd_en), 64'(fe));
    check({tag, ".fd_flush"}, 64'(hz.fd_flush), 64'(ff));
    check({tag, ".de_flush"}, 64'(hz.de_flush), 64'(df));
    check({tag, ".pc_sel"}, 64'(hz.pc_sel), 64'(ps));
    check({tag, ".state"}, 64'(hz.state), 64'(st));
    if (!pe) st_exp++;
    if (ps) fl_exp++;
    @(posedge clk);
    #1;
  endtask
  task automatic perf(input string tag);
    check({tag, ".stall_cycles"}, 64'(hz.stall_cycles), PERF ? 64'(st_exp) : 64'd0);
    check({tag, ".flush_count"}, 64'(hz.flush_count), PERF ? 64'(fl_exp) : 64'd0);
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc_en", 64'(hz.pc_en), 0);
    check("rst.fd_en", 64'(hz.fd_en), 0);
    check("rst.fd_flush", 64'(hz.fd_flush), 1);
    check("rst.de_flush", 64'(hz.de_flush), 1);
    check("rst.pc_sel", 64'(hz.pc_sel), 0);
    check("rst.state", 64'(hz.state), 0);
    check("rst.mc_err", 64'(hz.mc_err), 0);
    perf("rst");
    rst_n = 1;
    step("run", 1, 1, 0, 0, 0, 0);
    hz.imem_ready = 0;
    step("imem_wait", 0, 0, 0, 0, 0, 0);
    hz.imem_ready = 1;
    load(5, 5, 1, 0, 0, 1);
    step("lu_rs1", 0, 0, 0, 1, 0, 0);
    idle();
    step("lu_after", 1, 1, 0, 0, 0, 0);
    load(7, 0, 0, 7, 1, 1);
    step("lu_rs2", 0, 0, 0, 1, 0, 0);
    load(7, 0, 0, 7, 0, 1);
    step("lu_unused", 1, 1, 0, 0, 0, 0);
    load(0, 0, 1, 0, 0, 1);
    step("lu_x0", 1, 1, 0, 0, 0, 0);
    load(9, 9, 1, 0, 0, 0);
    step("lu_invalid", 1, 1, 0, 0, 0, 0);
    idle();
    perf("pre_br");
    hz.branch_taken = 1; hz.branch_target = 32'h40;
    #1 check("br.redirect_pc", 64'(hz.redirect_pc), 64'h40);
    step("br", 1, 1'bx, 1, 1, 1, 0);
    hz.branch_taken = 0; hz.imem_ready = 0;
    for (int i = 0; i < 3; i++) step("refill_wait", 0, 0, 1, 0, 0, 2);
    hz.imem_ready = 1;
    step("refill_done", 1, 1, 0, 0, 0, 2);
    step("post_refill", 1, 1, 0, 0, 0, 0);
    perf("br");
    hz.branch_taken = 1; hz.branch_target = 32'h80; hz.mc_start = 1;
    step("br_over_mc", 1, 1'bx, 1, 1, 1, 0);
    hz.mc_start = 0; hz.imem_ready = 0; hz.branch_target = 32'h100;
    #1 check("rebr.redirect_pc", 64'(hz.redirect_pc), 64'h100);
    step("rebr", 1, 1'bx, 1, 1, 1, 2);
    idle();
    step("rebr_done", 1, 1, 0, 0, 0, 2);
    step("rebr_run", 1, 1, 0, 0, 0, 0);
    perf("rebr");
    load(5, 5, 1, 0, 0, 1);
    hz.mc_start = 1;
    step("mc_over_lu", 0, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 10; i++) begin
      hz.mc_done = (i == 9);
      hz.branch_taken = (i == 3);
      step("mc_wait", 0, 0, 0, 0, 0, 1);
    end
    idle();
    step("mc_done_run", 1, 1, 0, 0, 0, 0);
    check("mc_done.mc_err", 64'(hz.mc_err), 0);
    hz.mc_start = 1;
    step("to_start", 0, 0, 0, 0, 0, 0);
    hz.mc_start = 0;
    for (int i = 0; i < 64; i++) begin
      check("to_wait.mc_err", 64'(hz.mc_err), 0);
      step("to_wait", 0, 0, 0, 0, 0, 1);
    end
    check("to.mc_err", 64'(hz.mc_err), 1);
    step("to_run", 1, 1, 0, 0, 0, 0);
    step("to_run2", 1, 1, 0, 0, 0, 0);
    check("to.mc_err_sticky", 64'(hz.mc_err), 1);
    perf("to");
    hz.mc_start = 1;
    step("rst_mc_start", 0, 0, 0, 0, 0, 0);
    hz.mc_start = 0;
    step("rst_mc_wait", 0, 0, 0, 0, 0, 1);
    rst_n = 0;
    #1;
    check("arst.state", 64'(hz.state), 0);
    check("arst.mc_err", 64'(hz.mc_err), 0);
    check("arst.fd_flush", 64'(hz.fd_flush), 1);
    st_exp = 0; fl_exp = 0;
    perf("arst");
    @(posedge clk);
    #1 rst_n = 1;
    step("arst_run", 1, 1, 0, 0, 0, 0);
    hz.mc_start = 1;
    step("tie_start", 0, 0, 0, 0, 0, 0);
    hz.mc_start = 0;
    for (int i = 0; i < 64; i++) begin
      hz.mc_done = (i == 63);
      step("tie_wait", 0, 0, 0, 0, 0, 1);
    end
    hz.mc_done = 0;
    check("tie.mc_err", 64'(hz.mc_err), 0);
    step("tie_run", 1, 1, 0, 0, 0, 0);
    perf("tie");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
